// File: rtl/cpu_load_dump_ctrl.sv
// Bring-up sequencer for the RISC-V CPU. It packs host bytes into instruction memory,
// releases the CPU for a fixed window, then streams the debug readout port back as bytes.
module cpu_load_dump_ctrl #(
  parameter int NUM_INSTR  = 64,
  parameter int RUN_CYCLES = 250,
  parameter int DUMP_WORDS = 16
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        start,
  input  logic        dump_src,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [5:0]  imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        DataOrReg,
  output logic [4:0]  address,
  output logic [1:0]  vout_addr,
  input  logic [7:0]  value_i,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);
  localparam int RW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [5:0]    LAST_WORD = 6'(NUM_INSTR - 1);
  localparam logic [4:0]    LAST_ADDR = 5'(DUMP_WORDS - 1);
  localparam logic [RW-1:0] LAST_RUN  = RW'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WR, S_RUN, S_SET, S_CAP, S_OUT, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_byte_cnt;
  logic [5:0]    r_word_cnt;
  logic [31:0]   r_pack;
  logic [RW-1:0] r_run_cnt;
  logic          r_src;
  logic [4:0]    r_addr;
  logic [1:0]    r_sel;
  logic [7:0]    r_out_data;
  logic          w_in_fire;
  logic          w_last_byte;

  assign w_in_fire   = (r_state == S_LOAD) && in_valid;
  assign w_last_byte = (r_addr == LAST_ADDR) && (r_sel == 2'd0);

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_LOAD;
      S_LOAD: if (w_in_fire && (r_byte_cnt == 2'd3)) w_state_next = S_WR;
      S_WR:   w_state_next = (r_word_cnt == LAST_WORD) ? S_RUN : S_LOAD;
      S_RUN:  if (r_run_cnt == LAST_RUN) w_state_next = S_SET;
      S_SET:  w_state_next = S_CAP;
      S_CAP:  w_state_next = S_OUT;
      S_OUT:  if (out_ready) w_state_next = w_last_byte ? S_DONE : S_SET;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (r_state == S_LOAD);
    imem_we    = (r_state == S_WR);
    imem_waddr = r_word_cnt;
    imem_wdata = r_pack;
    cpu_hold   = (r_state != S_RUN);
    DataOrReg  = r_src;
    address    = r_addr;
    vout_addr  = r_sel;
    out_valid  = (r_state == S_OUT);
    out_data   = r_out_data;
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
  end

  // The write cycle deasserts in_ready, so the shift register is quiet while imem sees it.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_byte_cnt <= 2'd0;
      r_word_cnt <= 6'd0;
      r_pack     <= 32'd0;
      r_run_cnt  <= '0;
      r_src      <= 1'b0;
      r_addr     <= 5'd0;
      r_sel      <= 2'd3;
      r_out_data <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src      <= dump_src;
            r_byte_cnt <= 2'd0;
            r_word_cnt <= 6'd0;
            r_run_cnt  <= '0;
            r_addr     <= 5'd0;
            r_sel      <= 2'd3;
          end
        end
        S_LOAD: begin
          if (w_in_fire) begin
            r_pack     <= {r_pack[23:0], in_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_WR: begin
          r_word_cnt <= r_word_cnt + 6'd1;
          r_run_cnt  <= '0;
        end
        S_RUN: r_run_cnt <= r_run_cnt + RW'(1);
        S_CAP: r_out_data <= value_i;
        S_OUT: begin
          // The final byte leaves address parked on the last word so 32 words never wrap.
          if (out_ready) begin
            r_sel <= r_sel - 2'd1;
            if ((r_sel == 2'd0) && !w_last_byte) r_addr <= r_addr + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
